// File: rtl/phy_types_pkg.sv
// Shared types for the PHY transmit path: encoder symbol classes and comma arbitration.
package phy_types_pkg;

  localparam int unsigned COMMA_SEL_W = 3;

  typedef enum logic [COMMA_SEL_W-1:0] {
    IDLE_SEL         = 3'd0,
    ACK_SEL          = 3'd1,
    GRTCRED0_SEL     = 3'd2,
    GRTCRED1_SEL     = 3'd3,
    START_PACKET_SEL = 3'd4,
    DATA_SEL         = 3'd5,
    END_PACKET_SEL   = 3'd6
  } comma_sel_t;

  // Fixed-priority comma choice; IDLE_SEL means no comma is pending.
  function automatic comma_sel_t pick_comma(input logic ack_nz,
                                            input logic gc0_nz,
                                            input logic gc1_nz);
    comma_sel_t sel;
    sel = IDLE_SEL;
    if (ack_nz)      sel = ACK_SEL;
    else if (gc0_nz) sel = GRTCRED0_SEL;
    else if (gc1_nz) sel = GRTCRED1_SEL;
    return sel;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Pending-request counter that saturates at all-ones and never underflows.
module sat_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic [CNT_W-1:0] w_next;

  // A write and a launch in the same cycle cancel; a write into a full counter is dropped.
  always_comb begin
    w_next = r_count;
    if (inc && dec)                 w_next = r_count;
    else if (inc && r_count != MAX) w_next = r_count + CNT_W'(1);
    else if (dec && r_count != '0)  w_next = r_count - CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      r_count <= w_next;
      r_full  <= (w_next == MAX);
    end
  end

  assign count = r_count;
  assign full  = r_full;

endmodule

// File: rtl/phy_tx_scheduler.sv
// Schedules comma symbols and packet flits onto the PHY encoder, letting commas
// cut in between flits of a packet.
module phy_tx_scheduler
  import phy_types_pkg::*;
#(
  parameter int unsigned CNT_W = 3
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       ack_write,
  input  logic       grtcred0_write,
  input  logic       grtcred1_write,
  input  logic       data_write,
  input  logic       packet_done,
  input  logic       done,
  output comma_sel_t comma_sel,
  output logic       start,
  output logic       get_data,
  output logic       ack_cnt_full,
  output logic       grtcred0_full,
  output logic       grtcred1_full,
  output logic       send_data_cnt_full
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COMMA = 3'd1,
    ST_SOP   = 3'd2,
    ST_DATA  = 3'd3,
    ST_EOP   = 3'd4
  } state_t;

  state_t     r_state;
  comma_sel_t r_comma_sel;
  logic       r_start;
  logic       r_pend;
  logic       r_resume;

  logic [CNT_W-1:0] w_ack_cnt;
  logic [CNT_W-1:0] w_gc0_cnt;
  logic [CNT_W-1:0] w_gc1_cnt;
  logic [CNT_W-1:0] w_pkt_cnt;
  logic             w_done_ok;
  logic             w_dec_ack;
  logic             w_dec_gc0;
  logic             w_dec_gc1;
  logic             w_dec_pkt;
  comma_sel_t       w_comma_pick;

  // done only counts once the symbol is actually on the wire.
  assign w_done_ok = done && !r_start && !r_pend && (r_state != ST_IDLE);

  // Commas retire in their launch cycle; a packet retires when its EOP completes.
  assign w_dec_ack = r_start && (r_comma_sel == ACK_SEL);
  assign w_dec_gc0 = r_start && (r_comma_sel == GRTCRED0_SEL);
  assign w_dec_gc1 = r_start && (r_comma_sel == GRTCRED1_SEL);
  assign w_dec_pkt = w_done_ok && (r_state == ST_EOP);

  assign w_comma_pick = pick_comma(w_ack_cnt != '0, w_gc0_cnt != '0, w_gc1_cnt != '0);

  sat_counter #(.CNT_W(CNT_W)) u_ack_cnt (
    .CLK(CLK), .nRST(nRST), .inc(ack_write), .dec(w_dec_ack),
    .count(w_ack_cnt), .full(ack_cnt_full)
  );

  sat_counter #(.CNT_W(CNT_W)) u_gc0_cnt (
    .CLK(CLK), .nRST(nRST), .inc(grtcred0_write), .dec(w_dec_gc0),
    .count(w_gc0_cnt), .full(grtcred0_full)
  );

  sat_counter #(.CNT_W(CNT_W)) u_gc1_cnt (
    .CLK(CLK), .nRST(nRST), .inc(grtcred1_write), .dec(w_dec_gc1),
    .count(w_gc1_cnt), .full(grtcred1_full)
  );

  sat_counter #(.CNT_W(CNT_W)) u_pkt_cnt (
    .CLK(CLK), .nRST(nRST), .inc(data_write), .dec(w_dec_pkt),
    .count(w_pkt_cnt), .full(send_data_cnt_full)
  );

  // r_pend delays the first launch after an IDLE pick by one cycle.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state     <= ST_IDLE;
      r_comma_sel <= IDLE_SEL;
      r_start     <= 1'b0;
      r_pend      <= 1'b0;
      r_resume    <= 1'b0;
    end else begin
      r_start <= r_pend;
      r_pend  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_comma_pick != IDLE_SEL) begin
            r_comma_sel <= w_comma_pick;
            r_state     <= ST_COMMA;
            r_pend      <= 1'b1;
          end else if (w_pkt_cnt != '0) begin
            r_comma_sel <= START_PACKET_SEL;
            r_state     <= ST_SOP;
            r_pend      <= 1'b1;
          end
        end
        ST_COMMA: begin
          if (w_done_ok) begin
            if (r_resume) begin
              r_comma_sel <= DATA_SEL;
              r_state     <= ST_DATA;
              r_start     <= 1'b1;
              r_resume    <= 1'b0;
            end else begin
              r_comma_sel <= IDLE_SEL;
              r_state     <= ST_IDLE;
            end
          end
        end
        ST_SOP: begin
          if (w_done_ok) begin
            r_comma_sel <= DATA_SEL;
            r_state     <= ST_DATA;
            r_start     <= 1'b1;
          end
        end
        ST_DATA: begin
          if (w_done_ok) begin
            r_start <= 1'b1;
            if (packet_done) begin
              r_comma_sel <= END_PACKET_SEL;
              r_state     <= ST_EOP;
            end else if (w_comma_pick != IDLE_SEL) begin
              r_comma_sel <= w_comma_pick;
              r_state     <= ST_COMMA;
              r_resume    <= 1'b1;
            end
          end
        end
        ST_EOP: begin
          if (w_done_ok) begin
            r_comma_sel <= IDLE_SEL;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_comma_sel <= IDLE_SEL;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // The flit pop coincides with the done that completes it, so it cannot be registered.
  assign get_data  = nRST && w_done_ok && (r_state == ST_DATA);
  assign comma_sel = r_comma_sel;
  assign start     = r_start;

endmodule
